// File: rtl/servo_pwm_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : servo_pwm_sched
//  Description : Multi-channel servo PWM scheduler. One shared prescaler and
//                pulse timer drive the channels strictly one after another
//                inside a fixed frame, so at most one output is ever high.
//                Widths are staged through a register port and copied into
//                shadow registers at each frame boundary.
//  Revision    : 1.0 - initial release
// ============================================================================
module servo_pwm_sched #(
    parameter int CHANNELS    = 4,
    parameter int CLK_DIV     = 50,
    parameter int FRAME_TICKS = 20000,
    parameter int MIN_PULSE   = 500,
    parameter int MAX_PULSE   = 2500,
    parameter int W           = 12,
    parameter int ADDR_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [W-1:0]        wr_data,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                frame_start,
    output logic                active
);

    localparam int c_pre_w   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_frame_w = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam int c_ch_w    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [c_pre_w-1:0]   c_pre_last   = c_pre_w'(CLK_DIV - 1);
    localparam logic [c_frame_w-1:0] c_frame_last = c_frame_w'(FRAME_TICKS - 1);
    localparam logic [W-1:0]         c_min        = W'(MIN_PULSE);
    localparam logic [W-1:0]         c_max        = W'(MAX_PULSE);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_pulse = 2'd1;
    localparam logic [1:0] c_st_wait  = 2'd2;

    // Reject parameter sets that cannot produce a valid non-overlapping frame
    generate
        if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
            $error("servo_pwm_sched: CHANNELS must be in 1..8");
        end
        if (CHANNELS * MAX_PULSE > FRAME_TICKS) begin : g_bad_frame
            $error("servo_pwm_sched: CHANNELS*MAX_PULSE exceeds FRAME_TICKS");
        end
        if (MIN_PULSE < 1 || MIN_PULSE > MAX_PULSE) begin : g_bad_min
            $error("servo_pwm_sched: MIN_PULSE must be in 1..MAX_PULSE");
        end
        if (CLK_DIV < 1) begin : g_bad_div
            $error("servo_pwm_sched: CLK_DIV must be at least 1");
        end
        if (W < 31 && MAX_PULSE >= (1 << W)) begin : g_bad_width
            $error("servo_pwm_sched: W too narrow for MAX_PULSE");
        end
        if (ADDR_W < c_ch_w) begin : g_bad_addr
            $error("servo_pwm_sched: ADDR_W too narrow for CHANNELS");
        end
    endgenerate

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [W-1:0]        r_staging [CHANNELS];
    logic [W-1:0]        r_shadow  [CHANNELS];
    logic [c_pre_w-1:0]  r_pre;
    logic [c_frame_w-1:0] r_ftick;
    logic [W-1:0]        r_ptick;
    logic [c_ch_w-1:0]   r_ch;
    logic [c_ch_w-1:0]   w_ch_nxt;
    logic [CHANNELS-1:0] r_pwm;
    logic [CHANNELS-1:0] w_pwm_nxt;
    logic                r_fs;
    logic                w_fs_nxt;
    logic                w_tick;
    logic                w_frame_end;
    logic                w_pulse_end;
    logic                w_start;
    logic [W-1:0]        w_cur_width;
    logic                w_first_valid;
    logic [c_ch_w-1:0]   w_first_idx;
    logic                w_next_valid;
    logic [c_ch_w-1:0]   w_next_idx;

    // Write clamping: 0 disables, short pulses are stretched, long ones cut
    function automatic logic [W-1:0] f_clamp(input logic [W-1:0] v);
        if (v == '0)
            return '0;
        else if (v < c_min)
            return c_min;
        else if (v > c_max)
            return c_max;
        else
            return v;
    endfunction

    // Tick, frame-end and pulse-end decode from the shared counters
    always_comb begin
        w_tick      = (r_pre == c_pre_last);
        w_frame_end = (r_state != c_st_idle) && w_tick && (r_ftick == c_frame_last);
        w_cur_width = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (r_ch == c_ch_w'(i))
                w_cur_width = r_shadow[i];
        end
        w_pulse_end = (r_state == c_st_pulse) && w_tick && (r_ptick == w_cur_width - 1'b1);
        w_start     = enable && ((r_state == c_st_idle) || w_frame_end);
    end

    // Priority encoders: first enabled channel of the frame being loaded
    // (from staging, since shadow is captured on the same edge) and the next
    // enabled channel above the one currently running
    always_comb begin
        w_first_valid = 1'b0;
        w_first_idx   = '0;
        w_next_valid  = 1'b0;
        w_next_idx    = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (r_staging[i] != '0) begin
                w_first_valid = 1'b1;
                w_first_idx   = c_ch_w'(i);
            end
            if ((c_ch_w'(i) > r_ch) && (r_shadow[i] != '0)) begin
                w_next_valid = 1'b1;
                w_next_idx   = c_ch_w'(i);
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= c_st_idle;
        else
            r_state <= w_state_nxt;
    end

    // Next-state logic; frame restart wins over a pulse ending on the same edge
    always_comb begin
        w_state_nxt = r_state;
        w_ch_nxt    = r_ch;
        if (!enable) begin
            w_state_nxt = c_st_idle;
            w_ch_nxt    = '0;
        end else if (w_start) begin
            w_state_nxt = w_first_valid ? c_st_pulse : c_st_wait;
            w_ch_nxt    = w_first_idx;
        end else if (w_pulse_end) begin
            w_state_nxt = w_next_valid ? c_st_pulse : c_st_wait;
            w_ch_nxt    = w_next_idx;
        end
    end

    // Output decode: one-hot of the channel that will run after this edge
    always_comb begin
        w_pwm_nxt = '0;
        if (w_state_nxt == c_st_pulse)
            w_pwm_nxt[w_ch_nxt] = 1'b1;
        w_fs_nxt = w_start;
    end

    // Staging writes, shadow capture, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_staging[i] <= '0;
                r_shadow[i]  <= '0;
            end
            r_pre   <= '0;
            r_ftick <= '0;
            r_ptick <= '0;
            r_ch    <= '0;
            r_pwm   <= '0;
            r_fs    <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_en && (wr_addr == ADDR_W'(i)))
                    r_staging[i] <= f_clamp(wr_data);
            end
            if (w_start) begin
                for (int i = 0; i < CHANNELS; i++)
                    r_shadow[i] <= r_staging[i];
                r_pre   <= '0;
                r_ftick <= '0;
                r_ptick <= '0;
            end else if (w_state_nxt == c_st_idle) begin
                r_pre   <= '0;
                r_ftick <= '0;
                r_ptick <= '0;
            end else begin
                if (w_tick) begin
                    r_pre   <= '0;
                    r_ftick <= r_ftick + 1'b1;
                end else begin
                    r_pre <= r_pre + 1'b1;
                end
                if (w_pulse_end)
                    r_ptick <= '0;
                else if (w_tick && (r_state == c_st_pulse))
                    r_ptick <= r_ptick + 1'b1;
            end
            r_ch  <= w_ch_nxt;
            r_pwm <= w_pwm_nxt;
            r_fs  <= w_fs_nxt;
        end
    end

    assign pwm_out     = r_pwm;
    assign frame_start = r_fs;
    assign active      = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_servo_pwm_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_servo_pwm_sched
//  Description : Self-checking bench for servo_pwm_sched. A frame-position
//                reference model predicts every output each cycle; scenario
//                tasks add directed checks on pulse lengths and alignment.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_servo_pwm_sched;

    localparam int CH        = 4;
    localparam int DIV       = 2;
    localparam int FT        = 100;
    localparam int MINP      = 5;
    localparam int MAXP      = 20;
    localparam int WD        = 12;
    localparam int AW        = 3;
    localparam int FRAME_CYC = FT * DIV;

    typedef int arr_t [CH];

    typedef struct packed {
        logic                idle;
        logic                fs;
        logic [15:0]         cyc;
        logic [CH-1:0][7:0]  sh;
        logic [CH-1:0][7:0]  st;
    } mstate_t;

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic          enable  = 1'b0;
    logic          wr_en   = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [WD-1:0] wr_data = '0;
    logic [CH-1:0] pwm_out;
    logic          frame_start;
    logic          active;

    int n_checks = 0;
    int n_pass   = 0;

    mstate_t       m = '0;
    logic [CH+1:0] exp_vec;

    always #5 clk = ~clk;

    servo_pwm_sched #(
        .CHANNELS   (CH),
        .CLK_DIV    (DIV),
        .FRAME_TICKS(FT),
        .MIN_PULSE  (MINP),
        .MAX_PULSE  (MAXP),
        .W          (WD),
        .ADDR_W     (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .pwm_out    (pwm_out),
        .frame_start(frame_start),
        .active     (active)
    );

    function automatic int clamp_ref(input int v);
        if (v == 0) return 0;
        if (v < MINP) return MINP;
        if (v > MAXP) return MAXP;
        return v;
    endfunction

    // Reference: channels occupy back-to-back windows from the frame start
    function automatic logic [CH-1:0] pwm_ref(input mstate_t s);
        logic [CH-1:0] r;
        int t;
        int len;
        r = '0;
        t = 0;
        if (!s.idle) begin
            for (int c = 0; c < CH; c++) begin
                len = int'(s.sh[c]) * DIV;
                if (int'(s.cyc) >= t && int'(s.cyc) < t + len) r[c] = 1'b1;
                t = t + len;
            end
        end
        return r;
    endfunction

    function automatic mstate_t model_step(input mstate_t s, input logic r, input logic en,
                                           input logic we, input logic [AW-1:0] a,
                                           input logic [WD-1:0] d);
        mstate_t n;
        n = s;
        if (r) begin
            n = '0;
            n.idle = 1'b1;
            return n;
        end
        n.fs = 1'b0;
        if (!en) begin
            n.idle = 1'b1;
            n.cyc  = '0;
        end else if (s.idle || int'(s.cyc) == FRAME_CYC - 1) begin
            n.sh   = s.st;
            n.cyc  = '0;
            n.idle = 1'b0;
            n.fs   = 1'b1;
        end else begin
            n.cyc = s.cyc + 16'd1;
        end
        for (int c = 0; c < CH; c++) begin
            if (we && int'(a) == c) n.st[c] = 8'(clamp_ref(int'(d)));
        end
        return n;
    endfunction

    always @(posedge clk) m <= model_step(m, rst, enable, wr_en, wr_addr, wr_data);

    always_comb exp_vec = {pwm_ref(m), m.fs, ~m.idle};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_write(input int a, input int d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = WD'(d);
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // Observe one whole frame starting at the next frame_start; counts
    // per-channel high cycles, first-high offsets and model disagreements
    task automatic measure_frame(output arr_t hi, output arr_t rise, output arr_t exp_hi,
                                 output int period, output int mism);
        int n;
        mism   = 0;
        period = -1;
        for (int c = 0; c < CH; c++) begin
            hi[c] = 0; rise[c] = -1; exp_hi[c] = -1;
        end
        n = 0;
        while (frame_start !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (frame_start !== 1'b1) return;
        for (int c = 0; c < CH; c++) exp_hi[c] = int'(m.sh[c]) * DIV;
        n = 0;
        do begin
            if ({pwm_out, frame_start, active} !== exp_vec) mism++;
            for (int c = 0; c < CH; c++) begin
                if (pwm_out[c] === 1'b1) begin
                    if (rise[c] < 0) rise[c] = n;
                    hi[c]++;
                end
            end
            @(negedge clk);
            n++;
        end while (frame_start !== 1'b1 && n < 1000);
        if (frame_start === 1'b1) period = n;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; wr_en = 1'b1; wr_addr = '0; wr_data = WD'(10);
        repeat (3) @(negedge clk);
        n_checks++;
        if (pwm_out !== '0) $display("FAIL reset_pwm: got %b expected 0000", pwm_out);
        else n_pass++;
        n_checks++;
        if (frame_start !== 1'b0) $display("FAIL reset_frame_start: got %b expected 0", frame_start);
        else n_pass++;
        n_checks++;
        if (active !== 1'b0) $display("FAIL reset_active: got %b expected 0", active);
        else n_pass++;
        wr_en = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic test_zero_widths();
        arr_t hi, rise, eh;
        int per, mism;
        for (int f = 0; f < 2; f++) begin
            measure_frame(hi, rise, eh, per, mism);
            n_checks++;
            if (per !== FRAME_CYC) $display("FAIL zero_period: got %0d expected %0d", per, FRAME_CYC);
            else n_pass++;
            n_checks++;
            if ((hi[0] + hi[1] + hi[2] + hi[3]) !== 0)
                $display("FAIL zero_pwm_high_cycles: got %0d expected 0", hi[0] + hi[1] + hi[2] + hi[3]);
            else n_pass++;
            n_checks++;
            if (mism !== 0) $display("FAIL zero_model: got %0d differing cycles expected 0", mism);
            else n_pass++;
        end
        n_checks++;
        if (active !== 1'b1) $display("FAIL zero_active: got %b expected 1", active);
        else n_pass++;
    endtask

    task automatic test_widths();
        arr_t hi, rise, eh;
        int per, mism;
        arr_t want_hi;
        arr_t want_rise;
        want_hi   = '{20, 0, 30, 40};
        want_rise = '{0, -1, 20, 50};
        do_write(0, 10);
        do_write(1, 0);
        do_write(2, 15);
        do_write(3, 20);
        measure_frame(hi, rise, eh, per, mism);
        for (int c = 0; c < CH; c++) begin
            n_checks++;
            if (hi[c] !== want_hi[c]) $display("FAIL widths_high_ch%0d: got %0d expected %0d", c, hi[c], want_hi[c]);
            else n_pass++;
            n_checks++;
            if (rise[c] !== want_rise[c]) $display("FAIL widths_rise_ch%0d: got %0d expected %0d", c, rise[c], want_rise[c]);
            else n_pass++;
        end
        n_checks++;
        if (per !== FRAME_CYC) $display("FAIL widths_period: got %0d expected %0d", per, FRAME_CYC);
        else n_pass++;
        n_checks++;
        if (mism !== 0) $display("FAIL widths_model: got %0d differing cycles expected 0", mism);
        else n_pass++;
    endtask

    task automatic test_clamp();
        arr_t hi, rise, eh;
        int per, mism;
        int t_addr [3];
        int t_data [3];
        int t_hi0  [3];
        t_addr = '{0, 0, 5};
        t_data = '{3, 100, 7};
        t_hi0  = '{10, 40, 40};
        for (int k = 0; k < 3; k++) begin
            do_write(t_addr[k], t_data[k]);
            measure_frame(hi, rise, eh, per, mism);
            n_checks++;
            if (hi[0] !== t_hi0[k]) $display("FAIL clamp_ch0_case%0d: got %0d expected %0d", k, hi[0], t_hi0[k]);
            else n_pass++;
            n_checks++;
            if (hi[1] !== 0) $display("FAIL clamp_ch1_case%0d: got %0d expected 0", k, hi[1]);
            else n_pass++;
            n_checks++;
            if (mism !== 0) $display("FAIL clamp_model_case%0d: got %0d differing cycles expected 0", k, mism);
            else n_pass++;
        end
    endtask

    task automatic test_midframe_write();
        arr_t hi, rise, eh;
        int per, mism;
        do_write(0, 10);
        measure_frame(hi, rise, eh, per, mism);
        fork
            measure_frame(hi, rise, eh, per, mism);
            begin
                repeat (24) @(negedge clk);
                n_checks++;
                if (pwm_out !== 4'b0100) $display("FAIL mid_ch2_running: got %b expected 0100", pwm_out);
                else n_pass++;
                do_write(0, 20);
            end
        join
        n_checks++;
        if (hi[0] !== 20) $display("FAIL mid_current_ch0: got %0d expected 20", hi[0]);
        else n_pass++;
        n_checks++;
        if (mism !== 0) $display("FAIL mid_current_model: got %0d differing cycles expected 0", mism);
        else n_pass++;
        measure_frame(hi, rise, eh, per, mism);
        n_checks++;
        if (hi[0] !== 40) $display("FAIL mid_next_ch0: got %0d expected 40", hi[0]);
        else n_pass++;
        // Write timed onto the edge that starts the following frame
        repeat (FRAME_CYC - 1) @(negedge clk);
        do_write(0, 5);
        n_checks++;
        if (frame_start !== 1'b1) $display("FAIL edge_write_alignment: got %b expected 1", frame_start);
        else n_pass++;
        measure_frame(hi, rise, eh, per, mism);
        n_checks++;
        if (hi[0] !== 40) $display("FAIL edge_write_same_frame_ch0: got %0d expected 40", hi[0]);
        else n_pass++;
        measure_frame(hi, rise, eh, per, mism);
        n_checks++;
        if (hi[0] !== 10) $display("FAIL edge_write_next_frame_ch0: got %0d expected 10", hi[0]);
        else n_pass++;
    endtask

    task automatic test_enable_drop();
        arr_t hi, rise, eh;
        int per, mism;
        repeat (15) @(negedge clk);
        n_checks++;
        if (pwm_out !== 4'b0100) $display("FAIL drop_ch2_running: got %b expected 0100", pwm_out);
        else n_pass++;
        enable = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({pwm_out, active} !== 5'b0) $display("FAIL drop_outputs: got pwm=%b active=%b expected 0000/0", pwm_out, active);
        else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({pwm_out, frame_start, active} !== 6'b0) $display("FAIL drop_idle_hold: got %b expected 000000", {pwm_out, frame_start, active});
        else n_pass++;
        enable = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({frame_start, pwm_out} !== 5'b1_0001) $display("FAIL reenable_edge: got fs=%b pwm=%b expected 1/0001", frame_start, pwm_out);
        else n_pass++;
        measure_frame(hi, rise, eh, per, mism);
        n_checks++;
        if (hi[0] !== 10 || hi[2] !== 30) $display("FAIL reenable_widths: got ch0=%0d ch2=%0d expected 10/30", hi[0], hi[2]);
        else n_pass++;
        n_checks++;
        if (mism !== 0) $display("FAIL reenable_model: got %0d differing cycles expected 0", mism);
        else n_pass++;
    endtask

    task automatic test_rst_mid_frame();
        arr_t hi, rise, eh;
        int per, mism;
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({pwm_out, active} !== 5'b0) $display("FAIL rst_mid_outputs: got pwm=%b active=%b expected 0000/0", pwm_out, active);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({frame_start, pwm_out} !== 5'b1_0000) $display("FAIL rst_restart: got fs=%b pwm=%b expected 1/0000", frame_start, pwm_out);
        else n_pass++;
        measure_frame(hi, rise, eh, per, mism);
        n_checks++;
        if ((hi[0] + hi[1] + hi[2] + hi[3]) !== 0)
            $display("FAIL rst_staging_cleared: got %0d high cycles expected 0", hi[0] + hi[1] + hi[2] + hi[3]);
        else n_pass++;
        n_checks++;
        if (per !== FRAME_CYC) $display("FAIL rst_period: got %0d expected %0d", per, FRAME_CYC);
        else n_pass++;
    endtask

    task automatic test_random();
        arr_t hi, rise, eh;
        int per, mism;
        int a, d;
        for (int f = 0; f < 6; f++) begin
            fork
                measure_frame(hi, rise, eh, per, mism);
                begin
                    for (int k = 0; k < 3; k++) begin
                        repeat ($urandom_range(1, 50)) @(negedge clk);
                        a = int'($urandom_range(0, 7));
                        d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4095))
                                                         : int'($urandom_range(0, 25));
                        do_write(a, d);
                    end
                end
            join
            for (int c = 0; c < CH; c++) begin
                n_checks++;
                if (hi[c] !== eh[c]) $display("FAIL random_f%0d_ch%0d: got %0d expected %0d", f, c, hi[c], eh[c]);
                else n_pass++;
            end
            n_checks++;
            if (per !== FRAME_CYC) $display("FAIL random_f%0d_period: got %0d expected %0d", f, per, FRAME_CYC);
            else n_pass++;
            n_checks++;
            if (mism !== 0) $display("FAIL random_f%0d_model: got %0d differing cycles expected 0", f, mism);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_zero_widths();
        test_widths();
        test_clamp();
        test_midframe_write();
        test_enable_drop();
        test_rst_mid_frame();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
